// File: rtl/shared_pkg.sv
// shared_pkg: default APB widths and the master FSM state type shared across the APB slice
package shared_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: host request/response channel plus APB bus signals, with master and slave views
interface apb_master_if #(
    parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [2:0]            req_prot;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [2:0]            PPROT;
    logic                  PWRITE;
    logic                  PSELx;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PSTRB, PPROT, PWRITE, PSELx, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PSTRB, PPROT, PWRITE, PSELx, PENABLE
    );

endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master (IDLE/SETUP/ACCESS); define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states
module apb_master #(
    parameter int ADDR_WIDTH     = shared_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = shared_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          PCLK,
    input logic          PRESETn,
    apb_master_if.master bus
);
    import shared_pkg::*;

    apb_mst_state_e          state;
    logic                    req_ready_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic [2:0]              pprot_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PPROT     = pprot_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // FSM, request capture and one-cycle response pulse; misaligned requests are answered without touching the bus
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        if (bus.req_addr[1:0] != 2'b00) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            paddr_q     <= bus.req_addr;
                            pwdata_q    <= bus.req_wdata;
                            pstrb_q     <= bus.req_write ? bus.req_strb : '0;
                            pprot_q     <= bus.req_prot;
                            pwrite_q    <= bus.req_write;
                            psel_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                            state       <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.PSLVERR;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                        state       <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= IDLE;
                    end else
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and randomized transfers checked against a transaction-level expectation model
module tb_apb_master;

    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host transfer. The slave answers after 'waits' wait states; the expected
    // response and latency come from the transfer rules, not from any FSM model.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] rdata, input logic slverr);
        logic mis, to, exp_err, last;
        logic [31:0] exp_rdata;
        logic [3:0] exp_strb;
        logic [71:0] exp_fields;
        int acc;
        mis = addr[1:0] != 2'b00;
        acc = waits + 1;
        to = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        if (acc > TO) begin
            acc = TO;
            to = 1'b1;
        end
`endif
        exp_err = mis | to | slverr;
        exp_rdata = (mis | to | wr) ? 32'h0 : rdata;
        exp_strb = wr ? strb : 4'h0;
        exp_fields = {addr, wdata, exp_strb, prot, wr};
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_strb = strb;
        bus.req_prot = prot;
        chk("req_ready_before", bus.req_ready, 1);
        @(posedge PCLK);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        bus.req_strb = 4'($urandom);
        bus.req_prot = 3'($urandom);
        if (mis) begin
            chk("mis_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b11, 32'h0});
            chk("mis_psel", {bus.PSELx, bus.PENABLE}, 0);
            chk("mis_ready", bus.req_ready, 1);
            @(negedge PCLK);
            chk("mis_after", {bus.rsp_valid, bus.PSELx, bus.rsp_err}, 3'b001);
            return;
        end
        for (int k = 1; k <= acc + 1; k++) begin
            if (k == 1) begin
                chk("setup_phase", {bus.PSELx, bus.PENABLE, bus.req_ready, bus.rsp_valid}, 4'b1000);
                bus.PREADY = 1'($urandom);
            end else begin
                chk("access_phase", {bus.PSELx, bus.PENABLE, bus.req_ready, bus.rsp_valid}, 4'b1100);
                last = (k == acc + 1);
                bus.PREADY = last && !to;
                bus.PRDATA = last ? rdata : $urandom;
                bus.PSLVERR = last ? slverr : 1'($urandom);
            end
            chk("apb_fields", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.PWRITE}, exp_fields);
            @(negedge PCLK);
        end
        bus.PREADY = 1'b0;
        bus.PRDATA = $urandom;
        bus.PSLVERR = 1'($urandom);
        chk("rsp_pulse", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, exp_err, exp_rdata});
        chk("rsp_bus_idle", {bus.PSELx, bus.PENABLE, bus.req_ready}, 3'b001);
        @(negedge PCLK);
        chk("rsp_held", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b0, exp_err, exp_rdata});
    endtask

    initial begin
        logic [31:0] a;
        int w;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_strb = '0;
        bus.req_prot = '0;
        bus.PRDATA = '0;
        bus.PREADY = 1'b0;
        bus.PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("reset_outputs", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB,
                              bus.PPROT, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready}, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("ready_after_reset", bus.req_ready, 1);

        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0);
        xfer(1'b0, 32'h4000_0020, 32'h5555_AAAA, 4'hF, 3'd2, 3, 32'h1234_5678, 1'b0);
        xfer(1'b0, 32'h8000_0004, 32'h0, 4'h3, 3'd1, 0, 32'hCAFE_F00D, 1'b1);
        xfer(1'b1, 32'h0000_0013, 32'h1111_2222, 4'hF, 3'd0, 0, 32'h0, 1'b0);

        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr = 32'h0000_0100;
        @(posedge PCLK);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        chk("pre_reset_access", {bus.PSELx, bus.PENABLE}, 2'b11);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk("reset_mid_xfer", {bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.req_ready, bus.PADDR}, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("after_mid_reset", {bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.req_ready}, 4'b0001);

`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 32'hC000_0000, 32'h0, 4'h0, 3'd0, 40, 32'hFFFF_FFFF, 1'b0);
        xfer(1'b0, 32'hC000_0008, 32'h0, 4'h0, 3'd0, TO - 1, 32'hABCD_0123, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = $urandom_range(0, 4);
`ifdef APB_MASTER_TIMEOUT_EN
            if ($urandom_range(0, 5) == 0) w = $urandom_range(TO - 2, TO + 2);
`endif
            xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), w, $urandom,
                 $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
